inst_queue: RTL and testbench
=============================

Name: inst_queue

Overview:
- 2-wide instruction queue between the fetch unit and the two Decoder instances of the front end.
- Buffers fetched instruction/PC pairs in a circular FIFO and absorbs fetch bubbles and dispatch stalls.
- Presents the two oldest entries in program order to the decode slots every cycle.
- Flushes completely on a redirect from branch resolution or commit.

Parameters:
DEPTH, 8, number of entries; power of two, >= 4
PC_W, 32, PC width in bits

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  discard all entries (branch mispredict / exception redirect)
in_valid0  in  1  fetch slot 0 holds an instruction
in_valid1  in  1  fetch slot 1 holds an instruction (next sequential after slot 0)
in_inst0  in  32  slot 0 instruction word
in_inst1  in  32  slot 1 instruction word
in_pc0  in  PC_W  slot 0 PC
in_pc1  in  PC_W  slot 1 PC
in_ready  out  1  queue can accept two instructions this cycle
out_valid0  out  1  head entry valid, drives decode slot 0
out_valid1  out  1  head+1 entry valid, drives decode slot 1
out_inst0  out  32  head instruction word
out_inst1  out  32  head+1 instruction word
out_pc0  out  PC_W  head PC
out_pc1  out  PC_W  head+1 PC
deq_cnt  in  2  entries consumed by dispatch this cycle (0..2)
count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (async, rst_n low): head=0, tail=0, count=0.
  - Outputs during reset: out_valid0/1=0, in_ready=1, count=0.
  - out_inst*/out_pc* are don't-care while out_valid* is 0.
  - Storage array is not reset.
- Slot rules:
  - in_valid1 is honoured only when in_valid0=1.
  - in_valid1 with in_valid0=0 is ignored; nothing is enqueued from slot 1.
- Enqueue:
  - enq_n = in_valid0 + (in_valid0 & in_valid1), taken only when in_ready=1.
  - in_ready = (DEPTH - count) >= 2. It is a function of the registered count only, with no same-cycle credit from deq_cnt.
  - Valid/ready protocol: when in_ready=0, upstream holds inst/pc/valid stable. Offered instructions are not written.
  - Slot 0 is written at tail, slot 1 at tail+1 mod DEPTH.
  - tail advances by enq_n.
- Dequeue:
  - out_valid0 = count>=1; out_valid1 = count>=2.
  - Outputs read combinationally from the array at head and head+1 mod DEPTH.
  - Effective deq = min(deq_cnt, count); a deq_cnt of 3 or one above count is clamped.
  - head advances by the effective deq.
- count_next = count + enq_n - deq, updated on the rising clk edge.
- Simultaneous enqueue and dequeue in one cycle are both applied. Entries freed by dequeue become visible to in_ready next cycle.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally. The head+1 and tail+1 indices also wrap (DEPTH-1 -> 0).
- Full/empty:
  - count==DEPTH: in_ready=0, both outputs valid.
  - count==DEPTH-1: in_ready=0, even for a single-instruction offer.
  - count==0: out_valid0/1=0 and deq_cnt is ignored.
- flush:
  - Synchronous, with highest priority.
  - Next cycle: head=tail=0, count=0. Enqueue and dequeue in the flush cycle are discarded.
  - out_valid* remain driven from the pre-flush state during the flush cycle; dispatch gates them with flush.
- Ordering: strict program order. out slot 0 is always older than out slot 1.

Optional Feature:
IQ_BYPASS_EN
- Defined: when count==0 and flush=0, out_valid0/1, out_inst*, out_pc* mirror in_valid0/1, in_inst*, in_pc* in the same cycle (0-cycle latency).
  - Bypassed instructions covered by deq_cnt are not written.
  - Remaining bypassed instructions are enqueued normally, so at most 2-deq entries are written.
  - in_ready is unchanged (1 when empty).
- Undefined: minimum enqueue-to-out_valid latency is 1 cycle. Outputs come only from the array.

Test Plan:
- Reset with rst_n=0 mid-operation at count=5 -> count=0, out_valid0/1=0, in_ready=1 immediately, without waiting for a clk edge.
- Enqueue pairs (0x00000013@0x1000, 0x00100093@0x1004), then (0x00200113@0x1008, 0x00300193@0x100C), deq_cnt=0 -> count=4. out_pc0=0x1000, out_pc1=0x1004 (without bypass, visible from cycle after first enqueue).
- Fill with DEPTH=8 and deq_cnt=0 -> in_ready falls when count=7. Single in_valid0 at count=7 is not accepted; count stays 7, then reaches 8 only via a later pair path (none). Then deq_cnt=2 -> count=5 and in_ready=1 next cycle.
- Wrap: push and pop 2/cycle for 10 cycles with sequential PCs from 0x2000 -> out_pc0 sequence 0x2000, 0x2008, … is continuous across index 7->0, with no loss or duplication.
- flush=1 with in_valid0/1=1, deq_cnt=2, count=6 -> next cycle count=0, out_valid0=0. The next enqueue appears at out_pc0 with its own PC.
- IQ_BYPASS_EN defined, empty queue, in_valid0/1=1 (pc 0x3000/0x3004), deq_cnt=1 -> same cycle out_pc0=0x3000; next cycle count=1, out_pc0=0x3004.

Source files
------------

// File: rtl/inst_queue.sv
// inst_queue: 2-wide circular instruction queue between fetch and the two decode slots.
//   Ports: clk, rst_n (async active-low); flush; fetch side in_valid0/1, in_inst0/1, in_pc0/1,
//   in_ready; decode side out_valid0/1, out_inst0/1, out_pc0/1, deq_cnt; occupancy count.
//   Optional macro IQ_BYPASS_EN: an empty queue forwards fetch slots straight to the outputs.
module inst_queue #(
  parameter int DEPTH = 8,
  parameter int PC_W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid0,
  input  logic                       in_valid1,
  input  logic [31:0]                in_inst0,
  input  logic [31:0]                in_inst1,
  input  logic [PC_W-1:0]            in_pc0,
  input  logic [PC_W-1:0]            in_pc1,
  output logic                       in_ready,
  output logic                       out_valid0,
  output logic                       out_valid1,
  output logic [31:0]                out_inst0,
  output logic [31:0]                out_inst1,
  output logic [PC_W-1:0]            out_pc0,
  output logic [PC_W-1:0]            out_pc1,
  input  logic [1:0]                 deq_cnt,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [31:0] mem_inst [DEPTH];
  logic [PC_W-1:0] mem_pc [DEPTH];
  logic [AW-1:0] head, tail, head1, tail1;
  logic [1:0] enq_n, deq_lim, deq, skip, wr_n;
  logic byp;
  assign head1 = head + AW'(1);
  assign tail1 = tail + AW'(1);
  // Ready looks only at registered occupancy; same-cycle dequeue gives no credit.
  assign in_ready = count <= CW'(DEPTH - 2);
  assign enq_n = in_ready ? {1'b0, in_valid0} + {1'b0, in_valid0 & in_valid1} : 2'd0;
  assign deq_lim = (deq_cnt == 2'd3) ? 2'd2 : deq_cnt;
  assign deq = (CW'(deq_lim) > count) ? count[1:0] : deq_lim;
`ifdef IQ_BYPASS_EN
  assign byp = (count == '0) && !flush;
`else
  assign byp = 1'b0;
`endif
  // Bypassed instructions that dispatch consumes this cycle are never written.
  assign skip = byp ? ((deq_lim < enq_n) ? deq_lim : enq_n) : 2'd0;
  assign wr_n = enq_n - skip;
  assign out_valid0 = byp ? in_valid0 : (count >= CW'(1));
  assign out_valid1 = byp ? (in_valid0 & in_valid1) : (count >= CW'(2));
  assign out_inst0 = byp ? in_inst0 : mem_inst[head];
  assign out_inst1 = byp ? in_inst1 : mem_inst[head1];
  assign out_pc0 = byp ? in_pc0 : mem_pc[head];
  assign out_pc1 = byp ? in_pc1 : mem_pc[head1];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      head <= head + AW'(deq);
      tail <= tail + AW'(wr_n);
      count <= count + CW'(wr_n) - CW'(deq);
    end
  // A single skipped bypass entry means slot 1 is the first one stored.
  always_ff @(posedge clk)
    if (!flush) begin
      if (wr_n != 2'd0) begin
        mem_inst[tail] <= (skip == 2'd0) ? in_inst0 : in_inst1;
        mem_pc[tail] <= (skip == 2'd0) ? in_pc0 : in_pc1;
      end
      if (wr_n == 2'd2) begin
        mem_inst[tail1] <= in_inst1;
        mem_pc[tail1] <= in_pc1;
      end
    end
endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: directed self-checking bench for inst_queue (default build, DEPTH=8).
module tb_inst_queue;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic in_valid0 = 1'b0, in_valid1 = 1'b0;
  logic [31:0] in_inst0 = '0, in_inst1 = '0;
  logic [31:0] in_pc0 = '0, in_pc1 = '0;
  logic in_ready, out_valid0, out_valid1;
  logic [31:0] out_inst0, out_inst1, out_pc0, out_pc1;
  logic [1:0] deq_cnt = 2'd0;
  logic [3:0] count;
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_pc;

  inst_queue #(.DEPTH(8), .PC_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid0(in_valid0), .in_valid1(in_valid1),
    .in_inst0(in_inst0), .in_inst1(in_inst1),
    .in_pc0(in_pc0), .in_pc1(in_pc1),
    .in_ready(in_ready),
    .out_valid0(out_valid0), .out_valid1(out_valid1),
    .out_inst0(out_inst0), .out_inst1(out_inst1),
    .out_pc0(out_pc0), .out_pc1(out_pc1),
    .deq_cnt(deq_cnt), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic v1, input logic [31:0] pc0, input logic [1:0] d);
    in_valid0 = v0;
    in_valid1 = v1;
    in_pc0 = pc0;
    in_pc1 = pc0 + 32'd4;
    in_inst0 = {16'hA5A5, pc0[15:0]};
    in_inst1 = {16'hA5A5, pc0[15:0] + 16'd4};
    deq_cnt = d;
  endtask

  initial begin
    #2;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid0", 32'(out_valid0), 32'd0);
    chk("rst_valid1", 32'(out_valid1), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    #10 rst_n = 1'b1;
    step();
    drive(1, 1, 32'h1000, 2'd0);
    in_inst0 = 32'h00000013;
    in_inst1 = 32'h00100093;
    step();
    chk("pair1_count", 32'(count), 32'd2);
    chk("pair1_v0", 32'(out_valid0), 32'd1);
    chk("pair1_v1", 32'(out_valid1), 32'd1);
    chk("pair1_pc0", out_pc0, 32'h1000);
    chk("pair1_pc1", out_pc1, 32'h1004);
    chk("pair1_inst0", out_inst0, 32'h00000013);
    chk("pair1_inst1", out_inst1, 32'h00100093);
    drive(1, 1, 32'h1008, 2'd0);
    in_inst0 = 32'h00200113;
    in_inst1 = 32'h00300193;
    step();
    chk("pair2_count", 32'(count), 32'd4);
    chk("pair2_pc0", out_pc0, 32'h1000);
    chk("pair2_pc1", out_pc1, 32'h1004);
    drive(1, 1, 32'h1010, 2'd0);
    step();
    chk("fill6_count", 32'(count), 32'd6);
    chk("fill6_ready", 32'(in_ready), 32'd1);
    drive(1, 0, 32'h1018, 2'd0);
    step();
    chk("fill7_count", 32'(count), 32'd7);
    chk("fill7_ready", 32'(in_ready), 32'd0);
    drive(1, 0, 32'h101C, 2'd0);
    step();
    chk("blocked_count", 32'(count), 32'd7);
    drive(0, 0, 32'h0, 2'd2);
    step();
    chk("deq2_count", 32'(count), 32'd5);
    chk("deq2_ready", 32'(in_ready), 32'd1);
    chk("deq2_pc0", out_pc0, 32'h1008);
    chk("deq2_inst0", out_inst0, 32'h00200113);
    deq_cnt = 2'd3;
    step();
    chk("deq3_count", 32'(count), 32'd3);
    chk("deq3_pc0", out_pc0, 32'h1010);
    deq_cnt = 2'd2;
    step();
    chk("tail_count", 32'(count), 32'd1);
    chk("tail_pc0", out_pc0, 32'h1018);
    chk("tail_v1", 32'(out_valid1), 32'd0);
    deq_cnt = 2'd3;
    step();
    chk("clamp_count", 32'(count), 32'd0);
    chk("clamp_v0", 32'(out_valid0), 32'd0);
    deq_cnt = 2'd2;
    step();
    chk("empty_deq_count", 32'(count), 32'd0);
    drive(1, 1, 32'h2000, 2'd0);
    step();
    exp_pc = 32'h2000;
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, exp_pc + 32'd8, 2'd2);
      chk("wrap_pc0", out_pc0, exp_pc);
      chk("wrap_pc1", out_pc1, exp_pc + 32'd4);
      chk("wrap_inst1", out_inst1, {16'hA5A5, exp_pc[15:0] + 16'd4});
      step();
      exp_pc = exp_pc + 32'd8;
      chk("wrap_count", 32'(count), 32'd2);
    end
    chk("wrap_end_pc0", out_pc0, 32'h2050);
    drive(1, 1, 32'h2058, 2'd0);
    step();
    drive(1, 1, 32'h2060, 2'd0);
    step();
    chk("preflush_count", 32'(count), 32'd6);
    drive(1, 1, 32'h5000, 2'd2);
    flush = 1'b1;
    #1;
    chk("flush_cycle_v0", 32'(out_valid0), 32'd1);
    step();
    flush = 1'b0;
    drive(0, 1, 32'h6000, 2'd0);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_v0", 32'(out_valid0), 32'd0);
    chk("flush_ready", 32'(in_ready), 32'd1);
    step();
    chk("slot1_only_count", 32'(count), 32'd0);
    drive(1, 1, 32'h4000, 2'd0);
    step();
    chk("postflush_count", 32'(count), 32'd2);
    chk("postflush_pc0", out_pc0, 32'h4000);
    chk("postflush_inst0", out_inst0, 32'hA5A54000);
    drive(1, 1, 32'h4008, 2'd0);
    step();
    drive(1, 0, 32'h4010, 2'd0);
    step();
    drive(0, 0, 32'h0, 2'd0);
    chk("prerst_count", 32'(count), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_v0", 32'(out_valid0), 32'd0);
    chk("async_rst_v1", 32'(out_valid1), 32'd0);
    chk("async_rst_ready", 32'(in_ready), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
